// File: rtl/sumador_serie_2b.sv
`timescale 1ns/1ps
// Digit-serial WIDTH-bit adder: one 2-bit slice reused WIDTH/2 times with a
// registered carry, wrapped in an IDLE/RUN/DONE valid/ready controller.

module sum2b_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {2'b00, cin};
endmodule

module sumador_serie_2b #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             busy
);
  localparam int NSL = WIDTH / 2;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, sr, sr_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [1:0]       s_sum;
  logic             s_cout;
  logic             last;

  sum2b_slice u_slice (
    .a   (sa[1:0]),
    .b   (sb[1:0]),
    .cin (carry),
    .sum (s_sum),
    .cout(s_cout)
  );

  assign last = (cnt == CW'(NSL - 1));
  // Shift form also covers WIDTH=2, where sr[WIDTH-1:2] would be an empty slice.
  assign sr_nxt = (sr >> 2) | (WIDTH'(s_sum) << (WIDTH - 2));

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      sr     <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (in_valid) begin
          sa    <= op_a;
          sb    <= op_b;
          carry <= cin;
          cnt   <= '0;
        end
        RUN: begin
          sa    <= sa >> 2;
          sb    <= sb >> 2;
          sr    <= sr_nxt;
          carry <= s_cout;
          cnt   <= cnt + CW'(1);
          if (last) begin
            result <= sr_nxt;
            cout   <= s_cout;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sumador_serie_2b.sv
`timescale 1ns/1ps
// Scoreboard bench: a WIDTH=8 instance for directed cases and a WIDTH=2
// instance swept over every operand/carry combination.

module tb_sumador_serie_2b;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       iv8 = 1'b0, or8 = 1'b1, cin8 = 1'b0;
  logic       ir8, ov8, co8, busy8;
  logic [7:0] a8 = '0, b8 = '0, r8;
  logic       iv2 = 1'b0, or2 = 1'b1, cin2 = 1'b0;
  logic       ir2, ov2, co2, busy2;
  logic [1:0] a2 = '0, b2 = '0, r2;

  sumador_serie_2b #(.WIDTH(8)) u_d8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .op_a(a8), .op_b(b8),
    .cin(cin8), .out_valid(ov8), .out_ready(or8), .result(r8), .cout(co8), .busy(busy8)
  );
  sumador_serie_2b #(.WIDTH(2)) u_d2 (
    .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2), .op_a(a2), .op_b(b2),
    .cin(cin2), .out_valid(ov2), .out_ready(or2), .result(r2), .cout(co2), .busy(busy2)
  );

  int n_chk = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [8:0] q8[$];
  logic [2:0] q2[$];
  int         acc8 = 0, acc2 = 0;
  logic       pov8 = 1'b0, pov2 = 1'b0;
  logic [8:0] e8;
  logic [2:0] e2;

  // A reset edge discards whatever is in flight, so the queues are flushed.
  always @(negedge clk) begin
    if (reset) begin
      q8.delete();
      pov8 = 1'b0;
    end else begin
      if (ov8 && !pov8) check("lat8", cyc - acc8, 4);
      if (ov8 && or8) begin
        if (q8.size() == 0) check("unexp8", 1, 0);
        else begin
          e8 = q8.pop_front();
          check("sum8", {co8, r8}, e8);
        end
      end
      if (iv8 && ir8) begin
        q8.push_back(9'(a8) + 9'(b8) + 9'(cin8));
        acc8 = cyc + 1;
      end
      pov8 = ov8;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      q2.delete();
      pov2 = 1'b0;
    end else begin
      if (ov2 && !pov2) check("lat2", cyc - acc2, 1);
      if (ov2 && or2) begin
        if (q2.size() == 0) check("unexp2", 1, 0);
        else begin
          e2 = q2.pop_front();
          check("sum2", {co2, r2}, e2);
        end
      end
      if (iv2 && ir2) begin
        q2.push_back(3'(a2) + 3'(b2) + 3'(cin2));
        acc2 = cyc + 1;
      end
      pov2 = ov2;
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int t = 0;
    @(posedge clk); #1;
    a8 = a; b8 = b; cin8 = c; iv8 = 1'b1;
    while (!ir8 && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) check("tmo_acc8", 1, 0);
    @(posedge clk); #1;
    iv8 = 1'b0;
  endtask

  task automatic drain8();
    int t = 0;
    while (q8.size() != 0 && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("tmo_drain8", 1, 0);
  endtask

  task automatic drain2();
    int t = 0;
    while (q2.size() != 0 && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("tmo_drain2", 1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   t;
    logic seen;
    // reset held 2 cycles with in_valid high
    reset = 1'b1; iv8 = 1'b1; a8 = 8'hAB; b8 = 8'hCD; cin8 = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_ir", ir8, 1);
      check("rst_ov", ov8, 0);
      check("rst_busy", busy8, 0);
      check("rst_res", {co8, r8}, 9'h000);
    end
    reset = 1'b0; iv8 = 1'b0;
    @(negedge clk);
    check("idle_ir", ir8, 1);
    check("idle_busy", busy8, 0);
    check("rst_noacc", q8.size(), 0);

    // directed sums, including full carry ripple
    send8(8'h12, 8'h34, 1'b0); drain8();
    send8(8'hFF, 8'h01, 1'b0); drain8();
    send8(8'hA5, 8'h5A, 1'b1); drain8();
    send8(8'h80, 8'h80, 1'b1); drain8();

    // backpressure while new operands are offered
    or8 = 1'b0;
    send8(8'h33, 8'h45, 1'b0);
    t = 0;
    while (!ov8 && t < 50) begin @(posedge clk); #1; t++; end
    check("bp_ov_rise", ov8, 1);
    a8 = 8'h77; b8 = 8'h11; iv8 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_res", {co8, r8}, 9'h078);
      check("bp_ir", ir8, 0);
      check("bp_ov", ov8, 1);
    end
    @(posedge clk); #1;
    iv8 = 1'b0; or8 = 1'b1;
    @(posedge clk); #1;
    check("bp_ir_after", ir8, 1);
    seen = 1'b0;
    repeat (6) begin @(negedge clk); seen |= ov8; end
    check("bp_nocapture", seen, 0);

    // reset in the second RUN cycle
    send8(8'hFF, 8'hFF, 1'b0);
    @(posedge clk); #1;
    check("mid_busy", busy8, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_ir", ir8, 1);
    check("mid_ov", ov8, 0);
    check("mid_res", {co8, r8}, 9'h000);
    seen = 1'b0;
    repeat (8) begin @(negedge clk); seen |= ov8; end
    check("mid_noout", seen, 0);
    send8(8'h01, 8'h02, 1'b0); drain8();

    // exhaustive WIDTH=2, back-to-back
    iv2 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      {a2, b2, cin2} = 5'(i);
      t = 0;
      while (!ir2 && t < 20) begin @(posedge clk); #1; t++; end
      if (t >= 20) check("tmo_acc2", 1, 0);
      @(posedge clk); #1;
    end
    iv2 = 1'b0;
    drain2();
    drain8();
    check("q8_empty", q8.size(), 0);
    check("q2_empty", q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sumador_serie_2b.md
# sumador_serie_2b

Digit-serial adder that computes a WIDTH-bit sum two bits per clock with a registered carry. It sits directly downstream of the operand source and upstream of the result consumer. It wraps the team's combinational 2-bit adder slice (A[1:0], B[1:0], cin → sum[1:0], cout) in a load/run/deliver controller with valid/ready handshakes on both sides. It is the sequential stage that turns the 2-bit slice into a wide adder without replicating hardware.

## Interface
- WIDTH, 8, operand/result width; must be even and ≥ 2.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands on op_a/op_b/cin are valid.
- in_ready  out  1  block can accept operands (high only in IDLE).
- op_a  in  WIDTH  first operand, unsigned.
- op_b  in  WIDTH  second operand, unsigned.
- cin  in  1  carry-in for the full-width addition.
- out_valid  out  1  result/cout hold a completed sum.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  op_a + op_b + cin, modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- busy  out  1  high in RUN or DONE.

## Operation
- Three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid at the edge, latch op_a and op_b into shift registers sa and sb, set carry ← cin, set slice counter ← 0, and go to RUN.
- RUN, each cycle:
  - Slice inputs are sa[1:0], sb[1:0], and carry.
  - sa and sb shift right by 2.
  - The slice sum is shifted into the top 2 bits of the accumulator sr (sr shifts right by 2).
  - carry ← slice cout; counter increments.
  - When the counter = WIDTH/2−1, load the output registers result ← {sum, sr[WIDTH-1:2]} and cout ← slice cout, then go to DONE.
- DONE:
  - out_valid = 1.
  - On out_ready at the edge, go to IDLE.
- in_valid is ignored outside IDLE. Operands are not re-sampled after acceptance, so op_a/op_b may change freely.
- result/cout come from dedicated output registers. They hold the last completed value through IDLE and RUN and are updated only on RUN→DONE.
- Arithmetic is unsigned; {cout, result} = op_a + op_b + cin exactly. There is no overflow flag.
- Counter width is clog2(WIDTH/2), minimum 1.

## Timing
- Reset (any state, including mid-RUN or DONE):
  - Next state is IDLE, the in-flight operation is discarded, and the counter is cleared.
  - Outputs after the reset edge: in_ready=1, out_valid=0, busy=0, result=0, cout=0.
  - Internal sa, sb, sr, and carry are cleared.
- Latency:
  - Accept edge E0 (in_valid && in_ready).
  - RUN occupies edges E1..E(WIDTH/2).
  - out_valid rises after E(WIDTH/2), i.e. WIDTH/2 cycles after acceptance (4 for WIDTH=8, 1 for WIDTH=2).
- Backpressure: with out_valid high and out_ready low, result, cout, and out_valid remain stable indefinitely, and in_ready stays 0.
- Completion edge:
  - If out_ready is high in the first DONE cycle, DONE lasts exactly one cycle.
  - in_ready rises the cycle after the handshake; there is no same-cycle reload.
  - Minimum throughput is one addition per WIDTH/2+2 cycles.
- in_ready, out_valid, and busy are decoded from the state register only, with no combinational path from inputs.

## Test plan
- Reset then idle, WIDTH=8:
  - Assert reset 2 cycles with in_valid=1 → in_ready=1, out_valid=0, result=0x00, cout=0 after reset.
  - No acceptance occurs while reset is high.
- Basic sum, WIDTH=8:
  - Apply op_a=0x12, op_b=0x34, cin=0 → out_valid exactly 4 cycles after acceptance, result=0x46, cout=0.
- Full carry ripple, WIDTH=8:
  - Apply 0xFF+0x01, cin=0 → result=0x00, cout=1.
  - Apply 0xA5+0x5A, cin=1 → result=0x00, cout=1.
  - Apply 0x80+0x80, cin=1 → result=0x01, cout=1.
- Backpressure/ignored input, WIDTH=8:
  - Hold out_ready=0 for 3 cycles after out_valid, and drive in_valid=1 with 0x77/0x11 meanwhile → result holds, in_ready=0, new operands are not captured.
  - Raise out_ready → in_ready=1 the next cycle.
- Reset mid-operation, WIDTH=8:
  - Assert reset at the 2nd RUN cycle of 0xFF+0xFF → IDLE next cycle, out_valid never asserts, result=0x00.
  - A following 0x01+0x02 yields 0x03, cout=0.
- Exhaustive, WIDTH=2:
  - Drive all 32 combinations of op_a, op_b, cin back-to-back → {cout,result} = op_a+op_b+cin each time, 1-cycle latency.
  - Covers the slice table, e.g. 3+3+1 → sum 3, cout 1; 2+1+1 → sum 0, cout 1.
